// File: rtl/ball_collision_engine.sv
// ball_collision_engine
// Sequential N-ball elastic collision resolver. A start pulse in IDLE snapshots
// every ball's centre and velocity. The engine then walks all pairs (i<j) in
// fixed order. Each pair that overlaps and is approaching gets an equal-mass
// impulse along its line of centres. Later pairs see the velocities already
// updated by earlier pairs. All resolved velocities and per-pair hit flags are
// published together, along with a one-cycle done pulse.
//
// Ports
//   clk        system clock
//   rst        synchronous active-low reset
//   start      frame pulse, accepted only in IDLE
//   pos_x/y    unsigned ball centres, ball i at [i*CW +: CW]
//   vel_x/y    signed ball velocities, ball i at [i*VW +: VW]
//   vel_x/y_out resolved velocities (registered, held between frames)
//   hit        per-pair impulse flags, bit k = k-th pair (0,1),(0,2)..(1,2)..
//   hit_any    OR of hit
//   busy       high from accepted start until done
//   done       one-cycle pulse when the outputs update
module ball_collision_engine #(
  parameter  int N_BALL = 3,
  parameter  int CW     = 10,
  parameter  int VW     = 10,
  parameter  int BALL_D = 24,
  parameter  int RSH    = 16,
  parameter  int RECIP  = 114,
  localparam int P      = N_BALL * (N_BALL - 1) / 2,
  localparam int HW     = (P > 0) ? P : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_BALL*CW-1:0] pos_x,
  input  logic [N_BALL*CW-1:0] pos_y,
  input  logic [N_BALL*VW-1:0] vel_x,
  input  logic [N_BALL*VW-1:0] vel_y,
  output logic [N_BALL*VW-1:0] vel_x_out,
  output logic [N_BALL*VW-1:0] vel_y_out,
  output logic [HW-1:0]        hit,
  output logic                 hit_any,
  output logic                 busy,
  output logic                 done
);

  localparam int XW = (N_BALL > 1) ? $clog2(N_BALL) : 1;  // ball index width
  localparam int KW = (HW > 1) ? $clog2(HW) : 1;          // pair index width
  localparam int DW = VW + CW + 3;                        // dot product width
  localparam int PW = DW + CW + 1 + RSH + 2;              // impulse product width
  localparam int IW = PW - RSH;                           // shifted impulse width

  localparam logic signed [2*CW+2:0] D2      = (2*CW+3)'(BALL_D * BALL_D);
  localparam logic signed [RSH+1:0]  RECIP_S = (RSH+2)'(RECIP);
  localparam logic signed [IW:0]     VMAX    = (IW+1)'(2**(VW-1) - 1);
  localparam logic signed [IW:0]     VMIN    = (IW+1)'(-(2**(VW-1)));

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    CALC_DOT,
    CALC_IMP,
    APPLY,
    DONE
  } state_t;

  state_t state;

  // Working copy of the frame snapshot
  logic        [CW-1:0] wpx [N_BALL];
  logic        [CW-1:0] wpy [N_BALL];
  logic signed [VW-1:0] wvx [N_BALL];
  logic signed [VW-1:0] wvy [N_BALL];

  logic [XW-1:0] idx_i, idx_j;
  logic [KW-1:0] pair_k;
  logic [HW-1:0] pend;

  logic signed [CW:0]   dx_r, dy_r;
  logic signed [DW-1:0] dot_r;
  logic signed [IW-1:0] ix_r, iy_r;

  logic signed [CW:0]     dx_c, dy_c;
  logic signed [2*CW+2:0] dist2_c;
  logic signed [VW:0]     dvx_c, dvy_c;
  logic signed [DW-1:0]   dot_c;
  logic signed [PW-1:0]   prod_x_c, prod_y_c;
  logic signed [IW:0]     new_vxi_c, new_vyi_c, new_vxj_c, new_vyj_c;
  logic                   last_pair, wrap;
  logic [XW-1:0]          nxt_i, nxt_j;

  function automatic logic signed [VW-1:0] sat(input logic signed [IW:0] v);
    if (v > VMAX) return VW'(VMAX);
    if (v < VMIN) return VW'(VMIN);
    return VW'(v);
  endfunction

  always_comb begin
    // NOTE: every combinational signal is assigned on every pass, so no latch can be inferred.
    dx_c    = $signed({1'b0, wpx[idx_j]}) - $signed({1'b0, wpx[idx_i]});
    dy_c    = $signed({1'b0, wpy[idx_j]}) - $signed({1'b0, wpy[idx_i]});
    dist2_c = (2*CW+3)'(dx_c) * (2*CW+3)'(dx_c) + (2*CW+3)'(dy_c) * (2*CW+3)'(dy_c);

    // Relative velocity uses the live working values, so earlier pairs count
    dvx_c = (VW+1)'(wvx[idx_i]) - (VW+1)'(wvx[idx_j]);
    dvy_c = (VW+1)'(wvy[idx_i]) - (VW+1)'(wvy[idx_j]);
    dot_c = DW'(dvx_c) * DW'(dx_r) + DW'(dvy_c) * DW'(dy_r);

    // RECIP approximates 1/BALL_D^2 in 2^-RSH units; >>> floors the result
    prod_x_c = PW'(dot_r) * PW'(dx_r) * PW'(RECIP_S);
    prod_y_c = PW'(dot_r) * PW'(dy_r) * PW'(RECIP_S);

    new_vxi_c = (IW+1)'(wvx[idx_i]) - (IW+1)'(ix_r);
    new_vyi_c = (IW+1)'(wvy[idx_i]) - (IW+1)'(iy_r);
    new_vxj_c = (IW+1)'(wvx[idx_j]) + (IW+1)'(ix_r);
    new_vyj_c = (IW+1)'(wvy[idx_j]) + (IW+1)'(iy_r);

    // Pair walk: (i,j) -> (i,j+1), or (i+1,i+2) once j hits the last ball
    wrap      = (idx_j == XW'(N_BALL - 1));
    last_pair = wrap && (idx_i == XW'(N_BALL - 2));
    nxt_i     = wrap ? idx_i + XW'(1) : idx_i;
    nxt_j     = wrap ? idx_i + XW'(2) : idx_j + XW'(1);
  end

  // NOTE: all state uses non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit       <= '0;
      hit_any   <= 1'b0;
      vel_x_out <= '0;
      vel_y_out <= '0;
      idx_i     <= '0;
      idx_j     <= '0;
      pair_k    <= '0;
      pend      <= '0;
      dx_r      <= '0;
      dy_r      <= '0;
      dot_r     <= '0;
      ix_r      <= '0;
      iy_r      <= '0;
      // NOTE: the working arrays are reset as well, so an aborted frame leaves nothing stale.
      for (int b = 0; b < N_BALL; b++) begin
        wpx[b] <= '0;
        wpy[b] <= '0;
        wvx[b] <= '0;
        wvy[b] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int b = 0; b < N_BALL; b++) begin
              wpx[b] <= pos_x[b*CW +: CW];
              wpy[b] <= pos_y[b*CW +: CW];
              wvx[b] <= vel_x[b*VW +: VW];
              wvy[b] <= vel_y[b*VW +: VW];
            end
            idx_i  <= '0;
            idx_j  <= XW'(1);
            pair_k <= '0;
            pend   <= '0;
            busy   <= 1'b1;
            state  <= DETECT;
          end
        end

        DETECT: begin
          if (P == 0) begin
            state <= DONE;
          end else begin
            dx_r <= dx_c;
            dy_r <= dy_c;
            if (dist2_c <= D2) begin
              state <= CALC_DOT;
            end else begin
              idx_i  <= nxt_i;
              idx_j  <= nxt_j;
              pair_k <= pair_k + KW'(1);
              state  <= last_pair ? DONE : DETECT;
            end
          end
        end

        CALC_DOT: begin
          dot_r <= dot_c;
          if (dot_c > 0) begin
            state <= CALC_IMP;
          end else begin
            // Separating or resting contact: leave the pair alone
            idx_i  <= nxt_i;
            idx_j  <= nxt_j;
            pair_k <= pair_k + KW'(1);
            state  <= last_pair ? DONE : DETECT;
          end
        end

        CALC_IMP: begin
          ix_r  <= IW'(prod_x_c >>> RSH);
          iy_r  <= IW'(prod_y_c >>> RSH);
          state <= APPLY;
        end

        APPLY: begin
          wvx[idx_i]   <= sat(new_vxi_c);
          wvy[idx_i]   <= sat(new_vyi_c);
          wvx[idx_j]   <= sat(new_vxj_c);
          wvy[idx_j]   <= sat(new_vyj_c);
          pend[pair_k] <= 1'b1;
          idx_i        <= nxt_i;
          idx_j        <= nxt_j;
          pair_k       <= pair_k + KW'(1);
          state        <= last_pair ? DONE : DETECT;
        end

        DONE: begin
          for (int b = 0; b < N_BALL; b++) begin
            vel_x_out[b*VW +: VW] <= wvx[b];
            vel_y_out[b*VW +: VW] <= wvy[b];
          end
          hit     <= pend;
          hit_any <= |pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_collision_engine.sv
// Self-checking bench for ball_collision_engine. A frame-level model computes
// the resolved velocities, hit mask and latency from the input snapshot taken
// at each accepted start. A per-cycle compare checks busy, done and the
// outputs. Directed cases pin the model to hand-computed values, and a random
// phase drives clustered balls, stray starts, input churn and resets.
module tb_ball_collision_engine;

  localparam int N      = 3;
  localparam int CW     = 10;
  localparam int VW     = 10;
  localparam int BALL_D = 24;
  localparam int RSH    = 16;
  localparam int RECIP  = 114;
  localparam int P      = 3;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           start = 1'b0;
  logic [N*CW-1:0] pos_x = '0;
  logic [N*CW-1:0] pos_y = '0;
  logic [N*VW-1:0] vel_x = '0;
  logic [N*VW-1:0] vel_y = '0;
  logic [N*VW-1:0] vel_x_out, vel_y_out;
  logic [P-1:0]    hit;
  logic            hit_any, busy, done;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  ball_collision_engine #(
    .N_BALL(N), .CW(CW), .VW(VW), .BALL_D(BALL_D), .RSH(RSH), .RECIP(RECIP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .vel_x_out(vel_x_out), .vel_y_out(vel_y_out),
    .hit(hit), .hit_any(hit_any), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 511) return 511;
    if (v < -512) return -512;
    return int'(v);
  endfunction

  // Frame model: plain integer physics over all pairs in order
  function automatic void model(input logic [N*CW-1:0] px, input logic [N*CW-1:0] py,
                                input logic [N*VW-1:0] vx, input logic [N*VW-1:0] vy,
                                output logic [N*VW-1:0] ovx, output logic [N*VW-1:0] ovy,
                                output logic [P-1:0] h, output int lat);
    int x[N], y[N], u[N], w[N];
    longint dx, dy, dot, ix, iy;
    int k;
    for (int b = 0; b < N; b++) begin
      x[b] = int'(px[b*CW +: CW]);
      y[b] = int'(py[b*CW +: CW]);
      u[b] = int'($signed(vx[b*VW +: VW]));
      w[b] = int'($signed(vy[b*VW +: VW]));
    end
    h   = '0;
    lat = 1;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        dx = x[j] - x[i];
        dy = y[j] - y[i];
        if (dx*dx + dy*dy > BALL_D*BALL_D) begin
          lat += 1;
        end else begin
          dot = (u[i] - u[j]) * dx + (w[i] - w[j]) * dy;
          if (dot <= 0) begin
            lat += 2;
          end else begin
            lat += 4;
            ix = (dot * dx * RECIP) >>> RSH;
            iy = (dot * dy * RECIP) >>> RSH;
            u[i] = sat(u[i] - ix);
            w[i] = sat(w[i] - iy);
            u[j] = sat(u[j] + ix);
            w[j] = sat(w[j] + iy);
            h[k] = 1'b1;
          end
        end
        k++;
      end
    end
    for (int b = 0; b < N; b++) begin
      ovx[b*VW +: VW] = VW'(u[b]);
      ovy[b*VW +: VW] = VW'(w[b]);
    end
  endfunction

  // Expected output timeline derived from the frame model
  logic [N*VW-1:0] e_vx, e_vy, m_vx, m_vy;
  logic [P-1:0]    e_hit, m_hit;
  bit              e_busy, e_done;
  int              e_cnt, m_lat;

  always @(posedge clk) begin : exp_blk
    logic [N*VW-1:0] tvx, tvy;
    logic [P-1:0]    th;
    int              tl;
    e_done <= 1'b0;
    if (!rst) begin
      e_busy <= 1'b0;
      e_cnt  <= 0;
      e_vx   <= '0;
      e_vy   <= '0;
      e_hit  <= '0;
    end else if (!e_busy) begin
      if (start) begin
        model(pos_x, pos_y, vel_x, vel_y, tvx, tvy, th, tl);
        m_vx   <= tvx;
        m_vy   <= tvy;
        m_hit  <= th;
        m_lat  <= tl;
        e_busy <= 1'b1;
        e_cnt  <= 1;
      end
    end else if (e_cnt == m_lat) begin
      e_busy <= 1'b0;
      e_done <= 1'b1;
      e_vx   <= m_vx;
      e_vy   <= m_vy;
      e_hit  <= m_hit;
    end else begin
      e_cnt <= e_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("vel_x_out", vel_x_out, e_vx);
      check("vel_y_out", vel_y_out, e_vy);
      check("hit", hit, e_hit);
      check("hit_any", hit_any, |e_hit);
    end
  end

  task automatic set_ball(input int i, input int x, input int y, input int vx, input int vy);
    pos_x[i*CW +: CW] = CW'(x);
    pos_y[i*CW +: CW] = CW'(y);
    vel_x[i*VW +: VW] = VW'(vx);
    vel_y[i*VW +: VW] = VW'(vy);
  endtask

  function automatic int ovx(input int i);
    return int'($signed(vel_x_out[i*VW +: VW]));
  endfunction

  function automatic int ovy(input int i);
    return int'($signed(vel_y_out[i*VW +: VW]));
  endfunction

  // Pulse start and count edges from the accepting edge until done
  task automatic run_frame(output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    check("frame_done_seen", done, 1);
  endtask

  task automatic randomize_balls();
    for (int b = 0; b < N; b++) begin
      int vx, vy;
      if ($urandom % 3 == 0) begin
        vx = int'($urandom_range(0, 1023)) - 512;
        vy = int'($urandom_range(0, 1023)) - 512;
      end else begin
        vx = int'($urandom_range(0, 40)) - 20;
        vy = int'($urandom_range(0, 40)) - 20;
      end
      set_ball(b, 100 + int'($urandom_range(0, 40)), 100 + int'($urandom_range(0, 40)), vx, vy);
    end
  endtask

  initial begin
    int lat, dn;
    logic [N*VW-1:0] tvx, tvy;
    logic [P-1:0]    th;
    int              tl;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 checking = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vel_x", vel_x_out, 0);
    check("rst_hit", hit, 0);
    @(negedge clk) rst = 1'b1;

    // Head-on along X; also pins the model against hand values
    set_ball(0, 100, 100, 8, 0);
    set_ball(1, 124, 100, 0, 0);
    set_ball(2, 500, 500, 0, 0);
    model(pos_x, pos_y, vel_x, vel_y, tvx, tvy, th, tl);
    check("model_lat", tl, 7);
    check("model_hit", th, 3'b001);
    check("model_v1x", $signed(tvx[VW +: VW]), 8);
    run_frame(lat);
    check("x_lat", lat, 7);
    check("x_v0x", ovx(0), 0);
    check("x_v1x", ovx(1), 8);
    check("x_v1y", ovy(1), 0);
    check("x_hit", hit, 3'b001);
    check("x_hit_any", hit_any, 1);

    // Head-on along Y
    set_ball(0, 100, 100, 0, 8);
    set_ball(1, 100, 124, 0, 0);
    run_frame(lat);
    check("y_v0y", ovy(0), 0);
    check("y_v1y", ovy(1), 8);
    check("y_v1x", ovx(1), 0);

    // Overlapping but separating
    set_ball(0, 100, 100, -4, 0);
    set_ball(1, 124, 100, 0, 0);
    run_frame(lat);
    check("sep_lat", lat, 5);
    check("sep_v0x", ovx(0), -4);
    check("sep_hit", hit, 0);
    check("sep_hit_any", hit_any, 0);

    // Just out of contact, then just in contact
    set_ball(0, 100, 100, 8, 0);
    set_ball(1, 125, 100, 0, 0);
    run_frame(lat);
    check("far_lat", lat, 4);
    check("far_v0x", ovx(0), 8);
    check("far_hit", hit, 0);
    set_ball(1, 124, 100, 0, 0);
    run_frame(lat);
    check("touch_hit", hit, 3'b001);
    check("touch_v1x", ovx(1), 8);

    // Chain: momentum passes 0 -> 1 -> 2 within one frame
    set_ball(0, 100, 100, 8, 0);
    set_ball(1, 124, 100, 0, 0);
    set_ball(2, 148, 100, 0, 0);
    run_frame(lat);
    check("chain_lat", lat, 10);
    check("chain_v0x", ovx(0), 0);
    check("chain_v1x", ovx(1), 0);
    check("chain_v2x", ovx(2), 8);
    check("chain_hit", hit, 3'b101);

    // Oblique hit that drives ball 0 x below the signed range
    set_ball(0, 200, 200, -500, 500);
    set_ball(1, 216, 217, -500, -500);
    set_ball(2, 600, 600, 0, 0);
    run_frame(lat);
    check("sat_v0x", ovx(0), -512);
    check("sat_v0y", ovy(0), -2);
    check("sat_v1x", ovx(1), -27);
    check("sat_v1y", ovy(1), 2);

    // Reset during CALC_IMP aborts the frame
    set_ball(0, 100, 100, 8, 0);
    set_ball(1, 124, 100, 0, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_vel_x", vel_x_out, 0);
    check("abort_vel_y", vel_y_out, 0);
    check("abort_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    dn = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done) dn++;
    end
    check("abort_no_done", dn, 0);

    // Starts while busy and during the DONE cycle are ignored
    set_ball(0, 100, 100, 8, 0);
    set_ball(1, 124, 100, 0, 0);
    set_ball(2, 148, 100, 0, 0);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 4 || c == 10);
      @(posedge clk);
      #1 if (done) dn++;
    end
    start = 1'b0;
    check("one_done", dn, 1);
    check("busy_after_ignored", busy, 0);

    // Random churn: clustered balls, stray starts, input changes, resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom % 4 == 0) randomize_balls();
      start = ($urandom % 6 == 0);
      rst   = ($urandom % 200 != 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b1;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
